// File: rtl/jtag_debug_pkg.sv
// Shared constants and types for the system-clock side of the JTAG debug command path.
package jtag_debug_pkg;

    localparam int unsigned JTAG_SR_WIDTH = 38;
    localparam int unsigned JTAG_IR_WIDTH = 2;
    localparam int unsigned JTAG_ACT_BIT  = 35;

    typedef enum logic [JTAG_IR_WIDTH-1:0] {
        IR_OCIMEM    = 2'd0,
        IR_TRACEMEM  = 2'd1,
        IR_BREAK     = 2'd2,
        IR_TRACECTRL = 2'd3
    } jtag_ir_e;

    typedef enum logic {
        ST_IDLE,
        ST_PEND
    } hold_state_e;

endpackage

// File: rtl/jtag_debug_strobe_sync.sv
// Brings an asynchronous TCK-domain level into clk and emits a one-cycle pulse on its rising edge.
module jtag_debug_strobe_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic async_in,
    output logic evt
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   dly_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync_q <= '0;
            dly_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
            dly_q  <= sync_q[SYNC_STAGES-1];
        end
    end

    assign evt = sync_q[SYNC_STAGES-1] & ~dly_q;

endmodule

// File: rtl/jtag_debug_cmd_decoder.sv
// Captures JTAG update-DR commands into clk, holds them in a valid/ready stage and decodes
// them into per-instruction take_action / take_no_action strobes.
module jtag_debug_cmd_decoder
    import jtag_debug_pkg::*;
#(
    parameter int unsigned SR_WIDTH    = JTAG_SR_WIDTH,
    parameter int unsigned IR_WIDTH    = JTAG_IR_WIDTH,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned ACT_BIT     = JTAG_ACT_BIT
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     vs_uir,
    input  logic                     vs_udr,
    input  logic [IR_WIDTH-1:0]      ir_in,
    input  logic [SR_WIDTH-1:0]      sr,
    input  logic                     cmd_ready,
    input  logic                     ovf_clr,
    output logic [SR_WIDTH-1:0]      jdo,
    output logic [IR_WIDTH-1:0]      cmd_ir,
    output logic                     cmd_valid,
    output logic [2**IR_WIDTH-1:0]   take_action,
    output logic [2**IR_WIDTH-1:0]   take_no_action,
    output logic                     overflow
);

    logic                uir_evt;
    logic                udr_evt;
    logic [IR_WIDTH-1:0] ir_q;
    hold_state_e         state_q;
    hold_state_e         state_d;
    logic                load;
    logic                drop;

    jtag_debug_strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) u_uir_sync (
        .clk      (clk),
        .reset_n  (reset_n),
        .async_in (vs_uir),
        .evt      (uir_evt)
    );

    jtag_debug_strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) u_udr_sync (
        .clk      (clk),
        .reset_n  (reset_n),
        .async_in (vs_udr),
        .evt      (udr_evt)
    );

    assign cmd_valid = (state_q == ST_PEND);
    // A pending command being accepted this cycle frees the slot for a same-cycle capture.
    assign load      = udr_evt & (~cmd_valid | cmd_ready);
    assign drop      = udr_evt & cmd_valid & ~cmd_ready;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (udr_evt) state_d = ST_PEND;
            ST_PEND: if (cmd_ready && !udr_evt) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            ir_q     <= '0;
            jdo      <= '0;
            cmd_ir   <= '0;
            overflow <= 1'b0;
        end else begin
            state_q <= state_d;
            if (uir_evt) ir_q <= ir_in;
            if (load) begin
                jdo    <= sr;
                cmd_ir <= ir_in;
            end
            if (drop)         overflow <= 1'b1;
            else if (ovf_clr) overflow <= 1'b0;
        end
    end

    always_comb begin
        take_action    = '0;
        take_no_action = '0;
        if (cmd_valid && cmd_ready) begin
            take_action[cmd_ir]    = jdo[ACT_BIT];
            take_no_action[cmd_ir] = ~jdo[ACT_BIT];
        end
    end

endmodule

// File: tb/tb_jtag_debug_cmd_decoder.sv
// Directed self-checking bench for jtag_debug_cmd_decoder with default parameters.
module tb_jtag_debug_cmd_decoder;
    import jtag_debug_pkg::*;

    localparam int unsigned SRW = 38;

    logic           clk;
    logic           reset_n;
    logic           vs_uir;
    logic           vs_udr;
    logic [1:0]     ir_in;
    logic [SRW-1:0] sr;
    logic           cmd_ready;
    logic           ovf_clr;
    logic [SRW-1:0] jdo;
    logic [1:0]     cmd_ir;
    logic           cmd_valid;
    logic [3:0]     take_action;
    logic [3:0]     take_no_action;
    logic           overflow;

    int passed;
    int failed;
    int total;
    int strobe_cycles;

    jtag_debug_cmd_decoder #(
        .SR_WIDTH    (38),
        .IR_WIDTH    (2),
        .SYNC_STAGES (2),
        .ACT_BIT     (35)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .vs_uir         (vs_uir),
        .vs_udr         (vs_udr),
        .ir_in          (ir_in),
        .sr             (sr),
        .cmd_ready      (cmd_ready),
        .ovf_clr        (ovf_clr),
        .jdo            (jdo),
        .cmd_ir         (cmd_ir),
        .cmd_valid      (cmd_valid),
        .take_action    (take_action),
        .take_no_action (take_no_action),
        .overflow       (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        passed = 0; failed = 0; total = 0;
        reset_n = 1'b0; vs_uir = 1'b0; vs_udr = 1'b0; ir_in = '0; sr = '0;
        cmd_ready = 1'b0; ovf_clr = 1'b0;
        repeat (3) tick();
        reset_n = 1'b1;
        #1;
        check("rst_valid", 64'(cmd_valid), 64'd0);
        check("rst_jdo", 64'(jdo), 64'd0);
        check("rst_ovf", 64'(overflow), 64'd0);
        check("rst_strobes", 64'({take_action, take_no_action}), 64'd0);

        // action command on IR_BREAK, ready already high
        tick();
        ir_in = IR_BREAK; sr = (38'd1 << 35) | 38'h5A; cmd_ready = 1'b1; vs_udr = 1'b1;
        tick(); tick();
        check("t1_not_yet", 64'(cmd_valid), 64'd0);
        tick();
        check("t1_valid", 64'(cmd_valid), 64'd1);
        check("t1_jdo", 64'(jdo[7:0]), 64'h5A);
        check("t1_cmd_ir", 64'(cmd_ir), 64'd2);
        check("t1_act", 64'(take_action), 64'b0100);
        check("t1_noact", 64'(take_no_action), 64'd0);
        tick();
        check("t1_act_once", 64'(take_action), 64'd0);
        check("t1_valid_clr", 64'(cmd_valid), 64'd0);
        check("t1_jdo_hold", 64'(jdo[7:0]), 64'h5A);
        tick();
        vs_udr = 1'b0;
        repeat (4) tick();

        // no-action command on IR_OCIMEM
        ir_in = IR_OCIMEM; sr = 38'h11; vs_udr = 1'b1;
        repeat (3) tick();
        check("t2_noact", 64'(take_no_action), 64'b0001);
        check("t2_act", 64'(take_action), 64'd0);
        tick();
        check("t2_noact_once", 64'(take_no_action), 64'd0);
        tick();
        vs_udr = 1'b0;
        repeat (4) tick();

        // back-pressure: command on IR_TRACEMEM held unaccepted
        cmd_ready = 1'b0; ir_in = IR_TRACEMEM; sr = (38'd1 << 35) | 38'h5A; vs_udr = 1'b1;
        repeat (3) tick();
        check("t3_valid", 64'(cmd_valid), 64'd1);
        repeat (2) tick();
        vs_udr = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("t3_hold_valid", 64'(cmd_valid), 64'd1);
            check("t3_hold_quiet", 64'({take_action, take_no_action}), 64'd0);
        end

        // second command dropped; clear requested in the drop cycle loses to set
        ir_in = IR_TRACECTRL; sr = 38'h33; vs_udr = 1'b1;
        repeat (2) tick();
        ovf_clr = 1'b1;
        tick();
        check("t4_ovf_set_wins", 64'(overflow), 64'd1);
        check("t4_jdo_kept", 64'(jdo[7:0]), 64'h5A);
        check("t4_cmd_ir_kept", 64'(cmd_ir), 64'd1);
        tick();
        check("t4_ovf_clr", 64'(overflow), 64'd0);
        ovf_clr = 1'b0;
        tick();
        vs_udr = 1'b0;
        repeat (4) tick();
        check("t4_ovf_stays_clr", 64'(overflow), 64'd0);
        cmd_ready = 1'b1;
        #1;
        check("t4_accept_act", 64'(take_action), 64'b0010);
        check("t4_accept_noact", 64'(take_no_action), 64'd0);
        tick();
        check("t4_valid_clr", 64'(cmd_valid), 64'd0);
        check("t4_strobe_once", 64'(take_action), 64'd0);
        check("t4_jdo_hold", 64'(jdo[7:0]), 64'h5A);
        repeat (3) tick();

        // long level gives a single capture
        ir_in = IR_OCIMEM; sr = (38'd1 << 35) | 38'h77; vs_udr = 1'b1;
        strobe_cycles = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if ((take_action | take_no_action) != 4'd0) strobe_cycles++;
        end
        check("t5_one_capture", 64'(strobe_cycles), 64'd1);
        vs_udr = 1'b0;
        repeat (4) tick();

        // simultaneous update-IR and update-DR
        cmd_ready = 1'b0; ir_in = IR_TRACECTRL; sr = 38'h44; vs_uir = 1'b1; vs_udr = 1'b1;
        repeat (3) tick();
        check("t6_valid", 64'(cmd_valid), 64'd1);
        check("t6_cmd_ir", 64'(cmd_ir), 64'd3);
        check("t6_jdo", 64'(jdo[7:0]), 64'h44);
        vs_uir = 1'b0; vs_udr = 1'b0;
        repeat (4) tick();

        // force an overflow, then reset mid-operation discards everything
        sr = 38'h55; vs_udr = 1'b1;
        repeat (3) tick();
        check("t7_ovf_pre", 64'(overflow), 64'd1);
        vs_udr = 1'b0;
        tick();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1; cmd_ready = 1'b1;
        #1;
        check("t7_valid", 64'(cmd_valid), 64'd0);
        check("t7_jdo", 64'(jdo), 64'd0);
        check("t7_ovf", 64'(overflow), 64'd0);
        check("t7_no_strobe", 64'({take_action, take_no_action}), 64'd0);
        tick();
        check("t7_no_strobe_next", 64'({take_action, take_no_action}), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/jtag_debug_cmd_decoder.md
Name: jtag_debug_cmd_decoder

Overview:
Generalised system-clock-side command decoder for the Nios II JTAG debug module. It takes the virtual-JTAG update strobes, instruction register and data shift register from the TCK domain, and synchronises the strobes into clk. It captures the data word and decodes it into per-instruction take_action / take_no_action strobes. Unlike the fixed 2-bit-IR / 38-bit design, it is parametrised in IR width, shift-register width, synchroniser depth and action-bit position. It also adds a valid/ready hold stage with sticky overflow reporting toward the debug core.

Parameters:
SR_WIDTH, 38, width of the TCK-domain shift register and of jdo
IR_WIDTH, 2, virtual JTAG instruction width; NUM_CMD = 2**IR_WIDTH command channels
SYNC_STAGES, 2, flops in each strobe synchroniser (legal 2..4)
ACT_BIT, 35, jdo bit selecting take_action (1) or take_no_action (0); must be < SR_WIDTH

Ports:
clk  in  1  system clock
reset_n  in  1  synchronous active-low reset
vs_uir  in  1  update-IR level from TCK domain, asynchronous to clk
vs_udr  in  1  update-DR level from TCK domain, asynchronous to clk
ir_in  in  IR_WIDTH  instruction register, stable while vs_uir/vs_udr high
sr  in  SR_WIDTH  shift register, stable while vs_udr high
cmd_ready  in  1  debug core accepts the pending command
ovf_clr  in  1  clears sticky overflow
jdo  out  SR_WIDTH  captured data word
cmd_ir  out  IR_WIDTH  instruction associated with jdo
cmd_valid  out  1  command pending
take_action  out  NUM_CMD  one-hot strobe, bit k = instruction k with jdo[ACT_BIT]=1
take_no_action  out  NUM_CMD  one-hot strobe, bit k = instruction k with jdo[ACT_BIT]=0
overflow  out  1  sticky: a command was dropped

Behaviour:
- Reset: sync chains, edge flops, ir_q, jdo, cmd_ir, cmd_valid and overflow are 0; take_* are 0. Reset is honoured mid-operation, and a pending command is discarded.
- Each of vs_uir and vs_udr passes through SYNC_STAGES flops plus one delay flop. The rising edge (last stage high, delay flop low) gives a single-cycle uir_evt / udr_evt.
- Latency: input first sampled high at edge k -> evt is high in the cycle after edge k+SYNC_STAGES-1 -> capture at edge k+SYNC_STAGES. With SYNC_STAGES=2, cmd_valid is visible after edge k+2.
- A level held high for many cycles produces exactly one evt. The level must be low for at least SYNC_STAGES+1 clk cycles before the next edge is detected.
- uir_evt: ir_q <= ir_in.
- udr_evt with cmd_valid=0, or with cmd_valid=1 and cmd_ready=1 in the same cycle: jdo <= sr, cmd_ir <= ir_in, cmd_valid <= 1.
- udr_evt while cmd_valid=1 and cmd_ready=0: the new command is dropped; jdo and cmd_ir are unchanged; overflow <= 1.
- Simultaneous uir_evt and udr_evt: ir_q and cmd_ir both take ir_in.
- Hold stage FSM, two states:
  - IDLE: cmd_valid=0; udr_evt -> PEND.
  - PEND: cmd_valid=1; cmd_ready with no udr_evt -> IDLE; cmd_ready with udr_evt -> PEND (new command loaded).
- Strobes (combinational from registers): take_action[k] = cmd_valid & cmd_ready & (cmd_ir==k) & jdo[ACT_BIT]. take_no_action[k] is the same with ~jdo[ACT_BIT]. At most one bit of the combined take_action|take_no_action vector is high in any cycle.
- jdo holds its value after acceptance until the next accepted capture.
- Overflow: ovf_clr clears it. If ovf_clr and a drop occur in the same cycle, set wins.
- ir_q is informational only and is exported to no port other than via cmd_ir capture.

Decomposition:
- Package jtag_debug_pkg: IR code constants (IR_OCIMEM=0, IR_TRACEMEM=1, IR_BREAK=2, IR_TRACECTRL=3 for IR_WIDTH=2) and the default SR_WIDTH / ACT_BIT constants.
- One sub-module, jtag_debug_strobe_sync (params SYNC_STAGES; ports clk, reset_n, async_in, evt). It is instantiated twice.

Test Plan:
- ir_in=2, sr with bit35=1 and low bits 0x5A; pulse vs_udr high for 5 clk, cmd_ready=1 -> after edge k+2, jdo[7:0]=0x5A, cmd_ir=2, take_action=4'b0100 for exactly one cycle, take_no_action=0.
- Same as above but sr bit35=0 and ir_in=0 -> take_no_action=4'b0001 once, take_action=0.
- cmd_ready=0 for 10 cycles after capture -> cmd_valid stays 1 and no strobes fire; raising cmd_ready -> a single strobe, then cmd_valid=0 on the next cycle.
- Second vs_udr pulse with sr low byte 0x33 while the first is unaccepted -> overflow=1 and jdo keeps 0x5A. Assert ovf_clr -> overflow=0. Then accept -> strobe uses cmd_ir of the first command.
- vs_udr held high 50 cycles -> exactly one capture. vs_uir and vs_udr rising together with ir_in=3 -> cmd_ir=3.
- reset_n low for one cycle while cmd_valid=1 -> next cycle cmd_valid=0, jdo=0, overflow=0, and no strobe even with cmd_ready=1.
